sdram_wbuf: RTL and testbench
=============================

SDRAM_WBUF -- requirements
Module: sdram_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-FIFO entry count (power of 2, 2..16).
REQ-002 SHALL have ports, clock and reset first:
- SDRAM_CLK  in  1  sole clock.
- CPU_RESn  in  1  reset, asynchronous, active-low.
- IN_CLKREF  in  1  upstream clock reference.
- IN_WE  in  1  upstream write strobe.
- IN_WADDR  in  25  upstream write address.
- IN_DIN  in  32  upstream write data.
- IN_BE  in  4  upstream byte enables.
- IN_WE_RDY  out  1  write slot free.
- IN_RD  in  1  upstream read strobe.
- IN_RADDR  in  25  upstream read address.
- IN_RD_RDY  out  1  read idle/complete.
- IN_DOUT  out  32  read data.
- OUT_CLKREF  out  1  to controller.
- OUT_WE  out  1  to controller.
- OUT_WADDR  out  25  to controller.
- OUT_DIN  out  32  to controller.
- OUT_BE  out  4  to controller.
- OUT_WE_RDY  in  1  from controller.
- OUT_RD  out  1  to controller.
- OUT_RADDR  out  25  to controller.
- OUT_RD_RDY  in  1  from controller.
- OUT_DOUT  in  32  from controller.
REQ-003 SHALL use one clock (SDRAM_CLK) and an asynchronous active-low reset (CPU_RESn), as already decided.

Function
REQ-004 SHALL post upstream writes into a DEPTH-entry FIFO of {WADDR, DIN, BE} and drain them to the controller in order.
REQ-005 SHALL accept a write on a cycle with IN_WE=1 and IN_WE_RDY=1, capturing address, data and BE that edge.
REQ-006 SHALL drive IN_WE_RDY=0 for exactly the one cycle after an accept, then IN_WE_RDY = (count<DEPTH) & read FSM in RD_IDLE.
REQ-007 SHALL hold IN_WE_RDY=0 while FIFO is full; IN_WE while not ready is ignored.
REQ-008 Drain FSM states: W_IDLE, W_ISSUE, W_BUSY.
- W_IDLE -> W_ISSUE when the FIFO is non-empty, OUT_WE_RDY=1, and the read FSM is not in RD_ISSUE/RD_BUSY.
- W_ISSUE: OUT_WE=1 for exactly one cycle with head entry; -> W_BUSY.
- W_BUSY: wait until OUT_WE_RDY=0 has been seen, then OUT_WE_RDY=1; pop the head; -> W_IDLE.
REQ-009 Read FSM states: RD_IDLE, RD_DRAIN, RD_ISSUE, RD_BUSY.
- RD_IDLE: IN_RD=1 with IN_RD_RDY=1 and no same-cycle write accept latches IN_RADDR; -> RD_DRAIN.
- RD_DRAIN: -> RD_ISSUE when the FIFO is empty, the drain FSM is in W_IDLE, and OUT_RD_RDY=1.
- RD_ISSUE: OUT_RD=1 for one cycle with latched address; -> RD_BUSY.
- RD_BUSY: after OUT_RD_RDY falls then rises -> RD_IDLE.
REQ-010 SHALL drive IN_RD_RDY=1 only in RD_IDLE; it is 0 from the cycle after read accept until RD_BUSY completes.
REQ-011 IN_DOUT SHALL equal OUT_DOUT combinationally; data is valid when IN_RD_RDY returns to 1.
REQ-012 OUT_WE and OUT_RD SHALL never be asserted in the same cycle.
REQ-013 Simultaneous IN_WE and IN_RD while both ready: the write is accepted and the read is not; the read is re-sampled later.
REQ-014 Accept and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-015 OUT_CLKREF SHALL equal IN_CLKREF | (count!=0) | (read FSM not RD_IDLE).
REQ-016 OUT_WADDR/DIN/BE SHALL show the FIFO head; OUT_RADDR SHALL show the latched read address.

Reset
REQ-017 On CPU_RESn=0, both FSMs go IDLE, count=0 and pointers=0, asynchronously.
REQ-018 Reset output values: OUT_WE=0, OUT_RD=0, IN_RD_RDY=1, IN_WE_RDY=1.
REQ-019 Reset mid-transfer SHALL discard all pending writes and any in-flight read without a further OUT strobe.

Structure
REQ-020 The entry typedef (waddr 25, din 32, be 4) and state enums SHALL live in package sdram_wbuf_pkg.
REQ-021 FIFO storage/pointers SHALL be sub-module sdram_wbuf_fifo; the FSMs remain in sdram_wbuf.

Verification
REQ-022 Single write 0x0100000/0xDEADBEEF/BE=0xF -> IN_WE_RDY low 1 cycle; one OUT_WE pulse with identical fields.
REQ-023 Five back-to-back writes with DEPTH=4 and the controller stalled -> IN_WE_RDY=0 after the 4th accept; the 5th is accepted only after the first pop.
REQ-024 Two writes then a read of the same address -> OUT_RD issued only after both OUT_WE completions; IN_DOUT returns the second write's data.
REQ-025 IN_WE and IN_RD high together -> only the write is accepted; the read completes afterwards.
REQ-026 CPU_RESn low while W_BUSY with 3 entries queued -> outputs at reset values immediately; no OUT_WE after release.

Source files
------------

// File: rtl/sdram_wbuf_pkg.sv
// Shared types for the SDRAM posted-write buffer: FIFO entry layout and FSM state encodings.
package sdram_wbuf_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] din;
        logic [BE_W-1:0]   be;
    } entry_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_BUSY
    } w_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_DRAIN,
        RD_ISSUE,
        RD_BUSY
    } rd_state_e;

endpackage

// File: rtl/sdram_wbuf_if.sv
// Push/pop channel between the buffer control logic (master) and the write FIFO (slave).
interface sdram_wbuf_if
    import sdram_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push;
    entry_t        push_data;
    logic          pop;
    entry_t        head;
    logic [CW-1:0] count;

    modport master (output push, push_data, pop, input  head, count);
    modport slave  (input  push, push_data, pop, output head, count);
endinterface

// File: rtl/sdram_wbuf_fifo.sv
// DEPTH-entry circular write FIFO; head is always visible, pointers wrap naturally (DEPTH is 2^n).
module sdram_wbuf_fifo
    import sdram_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_wbuf_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Storage is not reset: validity is tracked only by count/pointers.
    always_ff @(posedge clk) begin
        if (bus.push) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (bus.push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (bus.pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(bus.push) - CW'(bus.pop);
        end
    end

    assign bus.head  = mem_q[rd_ptr_q];
    assign bus.count = count_q;

endmodule

// File: rtl/sdram_wbuf.sv
// Posted-write buffer in front of an SDRAM controller: writes queue and drain in order,
// reads wait for the queue to drain so they always observe earlier writes.
module sdram_wbuf
    import sdram_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              SDRAM_CLK,
    input  logic              CPU_RESn,
    input  logic              IN_CLKREF,
    input  logic              IN_WE,
    input  logic [ADDR_W-1:0] IN_WADDR,
    input  logic [DATA_W-1:0] IN_DIN,
    input  logic [BE_W-1:0]   IN_BE,
    output logic              IN_WE_RDY,
    input  logic              IN_RD,
    input  logic [ADDR_W-1:0] IN_RADDR,
    output logic              IN_RD_RDY,
    output logic [DATA_W-1:0] IN_DOUT,
    output logic              OUT_CLKREF,
    output logic              OUT_WE,
    output logic [ADDR_W-1:0] OUT_WADDR,
    output logic [DATA_W-1:0] OUT_DIN,
    output logic [BE_W-1:0]   OUT_BE,
    input  logic              OUT_WE_RDY,
    output logic              OUT_RD,
    output logic [ADDR_W-1:0] OUT_RADDR,
    input  logic              OUT_RD_RDY,
    input  logic [DATA_W-1:0] OUT_DOUT
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    w_state_e          w_state_q;
    rd_state_e         rd_state_q;
    logic              we_rdy_q;
    logic              rd_rdy_q;
    logic              out_we_q;
    logic              out_rd_q;
    logic              w_seen_q;
    logic              rd_seen_q;
    logic [ADDR_W-1:0] raddr_q;

    logic              wr_acc;
    logic              rd_acc;
    logic              fifo_empty;
    logic              w_start;
    logic              w_done;
    logic              rd_start;
    logic              rd_done;
    logic              rd_idle_nxt;
    logic [CW-1:0]     count_nxt;

    sdram_wbuf_if #(.DEPTH(DEPTH)) fifo_if ();

    sdram_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (SDRAM_CLK),
        .rst_n (CPU_RESn),
        .bus   (fifo_if.slave)
    );

    // A write accept wins over a same-cycle read request; the read is simply retried.
    always_comb begin
        wr_acc      = IN_WE & we_rdy_q;
        rd_acc      = IN_RD & rd_rdy_q & ~wr_acc;
        fifo_empty  = (fifo_if.count == '0);
        w_start     = (w_state_q == W_IDLE) & ~fifo_empty & OUT_WE_RDY
                    & (rd_state_q != RD_ISSUE) & (rd_state_q != RD_BUSY);
        w_done      = (w_state_q == W_BUSY) & w_seen_q & OUT_WE_RDY;
        rd_start    = (rd_state_q == RD_DRAIN) & fifo_empty & (w_state_q == W_IDLE) & OUT_RD_RDY;
        rd_done     = (rd_state_q == RD_BUSY) & rd_seen_q & OUT_RD_RDY;
        rd_idle_nxt = ((rd_state_q == RD_IDLE) & ~rd_acc) | rd_done;
        count_nxt   = fifo_if.count + CW'(wr_acc) - CW'(w_done);
    end

    assign fifo_if.push      = wr_acc;
    assign fifo_if.push_data = '{waddr: IN_WADDR, din: IN_DIN, be: IN_BE};
    assign fifo_if.pop       = w_done;

    // Controller busy is a low-then-high pulse on its ready; the low may already show while the strobe is up.
    always_ff @(posedge SDRAM_CLK or negedge CPU_RESn) begin
        if (!CPU_RESn) begin
            w_state_q  <= W_IDLE;
            rd_state_q <= RD_IDLE;
            we_rdy_q   <= 1'b1;
            rd_rdy_q   <= 1'b1;
            out_we_q   <= 1'b0;
            out_rd_q   <= 1'b0;
            w_seen_q   <= 1'b0;
            rd_seen_q  <= 1'b0;
            raddr_q    <= '0;
        end else begin
            out_we_q <= 1'b0;
            out_rd_q <= 1'b0;
            we_rdy_q <= ~wr_acc & (count_nxt < CW'(DEPTH)) & rd_idle_nxt;
            rd_rdy_q <= rd_idle_nxt;

            case (w_state_q)
                W_IDLE: begin
                    if (w_start) begin
                        w_state_q <= W_ISSUE;
                        out_we_q  <= 1'b1;
                    end
                end
                W_ISSUE: begin
                    w_state_q <= W_BUSY;
                    w_seen_q  <= ~OUT_WE_RDY;
                end
                W_BUSY: begin
                    if (!OUT_WE_RDY) w_seen_q <= 1'b1;
                    if (w_done)      w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase

            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_acc) begin
                        raddr_q    <= IN_RADDR;
                        rd_state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (rd_start) begin
                        rd_state_q <= RD_ISSUE;
                        out_rd_q   <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    rd_state_q <= RD_BUSY;
                    rd_seen_q  <= ~OUT_RD_RDY;
                end
                RD_BUSY: begin
                    if (!OUT_RD_RDY) rd_seen_q  <= 1'b1;
                    if (rd_done)     rd_state_q <= RD_IDLE;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign IN_WE_RDY  = we_rdy_q;
    assign IN_RD_RDY  = rd_rdy_q;
    assign IN_DOUT    = OUT_DOUT;
    assign OUT_CLKREF = IN_CLKREF | ~fifo_empty | (rd_state_q != RD_IDLE);
    assign OUT_WE     = out_we_q;
    assign OUT_WADDR  = fifo_if.head.waddr;
    assign OUT_DIN    = fifo_if.head.din;
    assign OUT_BE     = fifo_if.head.be;
    assign OUT_RD     = out_rd_q;
    assign OUT_RADDR  = raddr_q;

endmodule

// File: tb/tb_sdram_wbuf.sv
// Bench for sdram_wbuf: behavioural SDRAM controller, in-order write scoreboard and byte-merged memory model.
module tb_sdram_wbuf;

    typedef struct packed {
        logic [24:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_clkref, in_we, in_rd;
    logic [24:0] in_waddr, in_raddr;
    logic [31:0] in_din, in_dout;
    logic [3:0]  in_be;
    logic        in_we_rdy, in_rd_rdy;
    logic        out_clkref, out_we, out_rd;
    logic [24:0] out_waddr, out_raddr;
    logic [31:0] out_din, out_dout;
    logic [3:0]  out_be;
    logic        out_we_rdy, out_rd_rdy;

    int total = 0;
    int bad   = 0;

    wr_t         exp_wq[$];
    logic [31:0] exp_mem [logic [24:0]];
    logic [31:0] ctl_mem [logic [24:0]];
    logic [24:0] ctl_raddr;
    int          wbusy = 0, rbusy = 0, we_pulses = 0, rd_pulses = 0, we_done = 0;
    bit          wpend = 0, stall = 0, long_busy = 0;

    always #5 clk = ~clk;

    sdram_wbuf #(.DEPTH(4)) dut (
        .SDRAM_CLK  (clk),
        .CPU_RESn   (rst_n),
        .IN_CLKREF  (in_clkref),
        .IN_WE      (in_we),
        .IN_WADDR   (in_waddr),
        .IN_DIN     (in_din),
        .IN_BE      (in_be),
        .IN_WE_RDY  (in_we_rdy),
        .IN_RD      (in_rd),
        .IN_RADDR   (in_raddr),
        .IN_RD_RDY  (in_rd_rdy),
        .IN_DOUT    (in_dout),
        .OUT_CLKREF (out_clkref),
        .OUT_WE     (out_we),
        .OUT_WADDR  (out_waddr),
        .OUT_DIN    (out_din),
        .OUT_BE     (out_be),
        .OUT_WE_RDY (out_we_rdy),
        .OUT_RD     (out_rd),
        .OUT_RADDR  (out_raddr),
        .OUT_RD_RDY (out_rd_rdy),
        .OUT_DOUT   (out_dout)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [24:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ctl_rd(input logic [24:0] a);
        return ctl_mem.exists(a) ? ctl_mem[a] : 32'h0;
    endfunction

    // Controller model and monitor: ready drops after each strobe, rises after a random latency.
    always @(negedge clk) begin
        wr_t e;
        if (out_we) begin
            we_pulses++;
            total++;
            if (exp_wq.size() == 0) begin
                bad++;
                $display("FAIL out_we_unexpected: got a=%h d=%h be=%h, required no write", out_waddr, out_din, out_be);
            end else begin
                e = exp_wq.pop_front();
                if ({out_waddr, out_din, out_be} !== e) begin
                    bad++;
                    $display("FAIL out_we_fields: got a=%h d=%h be=%h, required a=%h d=%h be=%h",
                             out_waddr, out_din, out_be, e.a, e.d, e.be);
                end
            end
            ctl_mem[out_waddr] = merge(ctl_rd(out_waddr), out_din, out_be);
            wbusy = long_busy ? 60 : int'($urandom_range(2, 5));
            wpend = 1'b1;
            out_we_rdy = 1'b0;
        end else begin
            if (wbusy > 0) wbusy--;
            if (wbusy == 0 && !stall) begin
                if (wpend) we_done++;
                wpend = 1'b0;
                out_we_rdy = 1'b1;
            end else if (wbusy == 0) begin
                out_we_rdy = 1'b0;
            end
        end

        if (out_rd) begin
            rd_pulses++;
            total++;
            if (exp_wq.size() != 0 || wpend || out_we) begin
                bad++;
                $display("FAIL rd_order: got out_rd with %0d writes pending, wpend=%0b, out_we=%0b, required 0/0/0",
                         exp_wq.size(), wpend, out_we);
            end
            ctl_raddr  = out_raddr;
            rbusy      = int'($urandom_range(2, 6));
            out_rd_rdy = 1'b0;
            out_dout   = $urandom;
        end else if (rbusy > 0) begin
            rbusy--;
            if (rbusy == 0) begin
                out_dout   = ctl_rd(ctl_raddr);
                out_rd_rdy = 1'b1;
            end
        end
    end

    task automatic do_write(input logic [24:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        in_we = 1'b1; in_waddr = a; in_din = d; in_be = be;
        while (in_we_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        total++;
        if (in_we_rdy !== 1'b1) begin
            bad++;
            $display("FAIL write_accept_timeout: in_we_rdy=%b after %0d cycles, required 1", in_we_rdy, n);
            in_we = 1'b0;
        end else begin
            exp_wq.push_back('{a: a, d: d, be: be});
            exp_mem[a] = merge(exp_rd(a), d, be);
            @(negedge clk);
            in_we = 1'b0;
        end
    endtask

    task automatic do_read(input logic [24:0] a, output logic [31:0] got);
        int n;
        bit side_bad;
        n = 0; side_bad = 0;
        in_rd = 1'b1; in_raddr = a;
        while (in_rd_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        in_rd = 1'b0;
        total++;
        if (in_rd_rdy !== 1'b0) begin
            bad++;
            $display("FAIL rd_rdy_drop: in_rd_rdy=%b after read accept, required 0", in_rd_rdy);
        end
        n = 0;
        while (in_rd_rdy !== 1'b1 && n < 300) begin
            if (in_we_rdy !== 1'b0 || out_clkref !== 1'b1) side_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        total++;
        if (in_rd_rdy !== 1'b1) begin
            bad++;
            $display("FAIL read_timeout: in_rd_rdy=%b after %0d cycles, required 1", in_rd_rdy, n);
        end
        total++;
        if (side_bad) begin
            bad++;
            $display("FAIL read_side: in_we_rdy/out_clkref wrong during read, required 0/1");
        end
        got = in_dout;
        total++;
        if (got !== exp_rd(a)) begin
            bad++;
            $display("FAIL read_data: addr=%h got %h, required %h", a, got, exp_rd(a));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_wq.size() == 0 && !wpend && rbusy == 0 && in_we_rdy === 1'b1 && in_rd_rdy === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL idle_timeout: pending=%0d we_rdy=%b rd_rdy=%b, required 0/1/1", exp_wq.size(), in_we_rdy, in_rd_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_clkref = 1'b0; in_we = 1'b0; in_rd = 1'b0;
        in_waddr = '0; in_raddr = '0; in_din = '0; in_be = '0;
        out_we_rdy = 1'b1; out_rd_rdy = 1'b1; out_dout = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({out_we, out_rd, in_rd_rdy, in_we_rdy, out_clkref} !== 5'b00110) begin
            bad++;
            $display("FAIL reset_outputs: we/rd/rd_rdy/we_rdy/clkref=%b, required 00110",
                     {out_we, out_rd, in_rd_rdy, in_we_rdy, out_clkref});
        end
        in_clkref = 1'b1;
        #1;
        total++;
        if (out_clkref !== 1'b1) begin
            bad++;
            $display("FAIL reset_clkref: out_clkref=%b with in_clkref=1, required 1", out_clkref);
        end
        in_clkref = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_we_rdy, in_rd_rdy, out_clkref} !== 3'b110) begin
            bad++;
            $display("FAIL post_reset: we_rdy/rd_rdy/clkref=%b, required 110", {in_we_rdy, in_rd_rdy, out_clkref});
        end
    endtask

    task automatic test_single_write();
        int p0;
        wait_idle();
        p0 = we_pulses;
        in_we = 1'b1; in_waddr = 25'h0100000; in_din = 32'hDEADBEEF; in_be = 4'hF;
        total++;
        if (in_we_rdy !== 1'b1) begin
            bad++;
            $display("FAIL single_ready: in_we_rdy=%b before write, required 1", in_we_rdy);
        end
        exp_wq.push_back('{a: 25'h0100000, d: 32'hDEADBEEF, be: 4'hF});
        exp_mem[25'h0100000] = 32'hDEADBEEF;
        @(negedge clk);
        in_we = 1'b0;
        total++;
        if (in_we_rdy !== 1'b0) begin
            bad++;
            $display("FAIL single_rdy_low: in_we_rdy=%b the cycle after accept, required 0", in_we_rdy);
        end
        @(negedge clk);
        total++;
        if (in_we_rdy !== 1'b1) begin
            bad++;
            $display("FAIL single_rdy_back: in_we_rdy=%b two cycles after accept, required 1", in_we_rdy);
        end
        wait_idle();
        total++;
        if (we_pulses - p0 != 1) begin
            bad++;
            $display("FAIL single_pulses: got %0d out_we pulses, required 1", we_pulses - p0);
        end
    endtask

    task automatic test_full();
        int p0, pd, n;
        bit held;
        wait_idle();
        stall = 1'b1;
        repeat (2) @(negedge clk);
        p0 = we_pulses;
        for (int i = 0; i < 4; i++) do_write(25'h0200000 + 25'(i), $urandom, 4'hF);
        held = 1'b1;
        in_we = 1'b1; in_waddr = 25'h0200004; in_din = 32'h5A5A0005; in_be = 4'h3;
        repeat (6) begin
            if (in_we_rdy !== 1'b0) held = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!held) begin
            bad++;
            $display("FAIL full_hold: in_we_rdy rose while 4 entries queued, required 0");
        end
        total++;
        if (we_pulses != p0 || out_clkref !== 1'b1) begin
            bad++;
            $display("FAIL full_stalled: pulses=%0d clkref=%b while stalled, required 0/1", we_pulses - p0, out_clkref);
        end
        pd = we_done;
        stall = 1'b0;
        n = 0;
        while (in_we_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        total++;
        if (in_we_rdy !== 1'b1 || we_done <= pd) begin
            bad++;
            $display("FAIL fifth_accept: we_rdy=%b completions=%0d at accept, required 1 and >=1", in_we_rdy, we_done - pd);
        end
        exp_wq.push_back('{a: 25'h0200004, d: 32'h5A5A0005, be: 4'h3});
        exp_mem[25'h0200004] = merge(exp_rd(25'h0200004), 32'h5A5A0005, 4'h3);
        @(negedge clk);
        in_we = 1'b0;
        wait_idle();
        total++;
        if (we_pulses - p0 != 5) begin
            bad++;
            $display("FAIL full_pulses: got %0d out_we pulses, required 5", we_pulses - p0);
        end
    endtask

    task automatic test_write_then_read();
        logic [24:0] a;
        logic [31:0] d1, d2, got;
        wait_idle();
        a = 25'($urandom); d1 = $urandom; d2 = $urandom;
        do_write(a, d1, 4'hF);
        do_write(a, d2, 4'hF);
        do_read(a, got);
        total++;
        if (got !== d2) begin
            bad++;
            $display("FAIL wr_wr_rd: got %h, required second write %h", got, d2);
        end
        wait_idle();
        total++;
        if (out_clkref !== 1'b0) begin
            bad++;
            $display("FAIL idle_clkref: out_clkref=%b when idle, required 0", out_clkref);
        end
    endtask

    task automatic test_simultaneous();
        logic [24:0] a;
        logic [31:0] d;
        int pr, n;
        wait_idle();
        a = 25'h1ABCDE; d = $urandom; pr = rd_pulses;
        in_we = 1'b1; in_waddr = a; in_din = d; in_be = 4'hF;
        in_rd = 1'b1; in_raddr = a;
        exp_wq.push_back('{a: a, d: d, be: 4'hF});
        exp_mem[a] = d;
        @(negedge clk);
        in_we = 1'b0;
        total++;
        if ({in_we_rdy, in_rd_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL simul_accept: we_rdy/rd_rdy=%b after both strobes, required 01", {in_we_rdy, in_rd_rdy});
        end
        @(negedge clk);
        in_rd = 1'b0;
        total++;
        if (in_rd_rdy !== 1'b0) begin
            bad++;
            $display("FAIL simul_read_resample: in_rd_rdy=%b, required 0", in_rd_rdy);
        end
        n = 0;
        while (in_rd_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        total++;
        if (in_dout !== d || rd_pulses - pr != 1) begin
            bad++;
            $display("FAIL simul_read: dout=%h rd_pulses=%0d, required %h and 1", in_dout, rd_pulses - pr, d);
        end
    endtask

    task automatic test_random();
        logic [24:0] a;
        logic [31:0] got;
        for (int i = 0; i < 60; i++) begin
            a = 25'h0300000 + 25'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 6) do_write(a, $urandom, 4'($urandom));
            else do_read(a, got);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
    endtask

    task automatic test_reset_midflight();
        int p0;
        wait_idle();
        long_busy = 1'b1;
        for (int i = 0; i < 4; i++) do_write(25'h0400000 + 25'(i), $urandom, 4'hF);
        total++;
        if (out_we_rdy !== 1'b0 || exp_wq.size() != 3) begin
            bad++;
            $display("FAIL midflight_setup: ctl_rdy=%b queued=%0d, required 0 and 3", out_we_rdy, exp_wq.size());
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_we, out_rd, in_rd_rdy, in_we_rdy, out_clkref} !== 5'b00110) begin
            bad++;
            $display("FAIL midflight_reset: we/rd/rd_rdy/we_rdy/clkref=%b, required 00110",
                     {out_we, out_rd, in_rd_rdy, in_we_rdy, out_clkref});
        end
        exp_wq.delete();
        long_busy = 1'b0; wbusy = 0; wpend = 1'b0; out_we_rdy = 1'b1;
        p0 = we_pulses;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (we_pulses != p0 || in_we_rdy !== 1'b1) begin
            bad++;
            $display("FAIL midflight_discard: %0d out_we after reset, we_rdy=%b, required 0 and 1", we_pulses - p0, in_we_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full();
        test_write_then_read();
        test_simultaneous();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
